// File: rtl/spi_slave.sv
// SPI slave front end for the SPI RAM: MOSI frames to rx_data words, RAM read data out on MISO.
// Define SPI_SLAVE_SVA_EN to compile in the protocol assertions.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int RW = ADDR_SIZE + 2;
  localparam int CW = $clog2(RW);
  localparam int TW = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RW-2:0]     shift_q, shift_d;
  logic              rx_done_q, rx_done_d;
  logic [RW-1:0]     rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rd_addr_ok_q, rd_addr_ok_d;
  logic [ADDR_SIZE-1:0] tx_sh_q, tx_sh_d;
  logic [TW-1:0]     tx_cnt_q, tx_cnt_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;
  logic              miso_q, miso_d;

  logic [RW-1:0]     rx_word;
  logic              rx_last;
  logic              tx_last;

  assign rx_word = {shift_q, MOSI};
  assign rx_last = (bit_cnt_q == CW'(RW - 1));
  assign tx_last = (tx_cnt_q == TW'(ADDR_SIZE));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_done_d    = rx_done_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rd_addr_ok_d = rd_addr_ok_q;
    tx_sh_d      = tx_sh_q;
    tx_cnt_d     = tx_cnt_q;
    tx_busy_d    = tx_busy_q;
    tx_done_d    = tx_done_q;
    miso_d       = 1'b0;
    if (SS_n) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      rx_done_d = 1'b0;
      tx_sh_d   = '0;
      tx_cnt_d  = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)             state_d = WRITE;
          else if (rd_addr_ok_q) state_d = READ_DATA;
          else                   state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          // bits after the tenth are dropped until the frame ends
          if (!rx_done_q) begin
            shift_d = rx_word[RW-2:0];
            if (rx_last) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              rx_done_d  = 1'b1;
              if (state_q == READ_ADD) rd_addr_ok_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          if (state_q == READ_DATA) begin
            if (tx_busy_q) begin
              if (tx_last) begin
                tx_busy_d    = 1'b0;
                tx_done_d    = 1'b1;
                rd_addr_ok_d = 1'b0;
              end else begin
                miso_d   = tx_sh_q[ADDR_SIZE-1];
                tx_sh_d  = tx_sh_q << 1;
                tx_cnt_d = tx_cnt_q + TW'(1);
              end
            end else if (rx_done_q && !tx_done_q && tx_valid) begin
              tx_sh_d   = tx_data;
              tx_cnt_d  = '0;
              tx_busy_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_done_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_ok_q <= 1'b0;
      tx_sh_q      <= '0;
      tx_cnt_q     <= '0;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_done_q    <= rx_done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rd_addr_ok_q <= rd_addr_ok_d;
      tx_sh_q      <= tx_sh_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
      miso_q       <= miso_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_SVA_EN
  logic ok_evt;
  assign ok_evt = !SS_n &&
    ((state_q == READ_ADD && !rx_done_q && rx_last) ||
     (state_q == READ_DATA && tx_busy_q && tx_last));

  a_rxv_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    rx_valid_q |=> !rx_valid_q);
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA});
  a_miso_idle: assert property (@(posedge clk) disable iff (!rst_n)
    SS_n |=> !miso_q);
  a_ok_change: assert property (@(posedge clk) disable iff (!rst_n)
    $changed(rd_addr_ok_q) |-> $past(ok_evt));
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frame table, reset-mid-read sequence,
// and random frames against an edge-indexed frame model.
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int total;
  int bad;

  bit         m_rd_ok;
  logic [9:0] m_rx;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (ss_n),
    .MOSI    (mosi),
    .MISO    (miso),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One frame: SS_n low for edges 0..n-1, high at edge n.
  // Select bit at edge 1, data MSB-first at edges 2..11.
  // RAM answers with tx_valid over edges 12+lat .. 12+lat+hold-1.
  task automatic run_frame(input bit sel, input logic [9:0] word,
                           input int n, input int lat, input int hold,
                           input logic [7:0] txb,
                           output int pulses, output logic [7:0] obyte);
    bit full;
    bit rdf;
    bit rd0;
    bit exp_v;
    bit exp_m;
    int c;
    full   = (n >= 12);
    rd0    = m_rd_ok;
    rdf    = full && sel && rd0 && (lat > 0);
    c      = 12 + lat;
    pulses = 0;
    obyte  = '0;
    tx_data = txb;
    for (int e = 0; e <= n; e++) begin
      @(negedge clk);
      ss_n = (e == n);
      if (e == 1)
        mosi = sel;
      else if (e >= 2 && e <= 11)
        mosi = word[11-e];
      else
        mosi = 1'($urandom_range(0, 1));
      tx_valid = (lat > 0) && (e >= c) && (e < c + hold);
      @(posedge clk);
      #1;
      exp_v = full && (e == 11);
      if (exp_v) begin
        m_rx = word;
        if (sel && !rd0) m_rd_ok = 1'b1;
      end
      if (rdf && e == c + 9 && e < n) m_rd_ok = 1'b0;
      exp_m = 1'b0;
      if (rdf && e < n && e >= c + 1 && e <= c + 8)
        exp_m = txb[7-(e-c-1)];
      chk("rx_valid", 32'(rx_valid), 32'(exp_v));
      chk("rx_data", 32'(rx_data), 32'(m_rx));
      chk("miso", 32'(miso), 32'(exp_m));
      chk("rd_addr_ok", 32'(dut.rd_addr_ok_q), 32'(m_rd_ok));
      if (rx_valid) pulses++;
      if (lat > 0 && e >= c + 1 && e <= c + 8)
        obyte[7-(e-c-1)] = miso;
    end
  endtask

  typedef struct {
    bit         sel;
    logic [9:0] word;
    int         n;
    int         lat;
    int         hold;
    logic [7:0] txb;
    int         e_pulses;
    logic [9:0] e_rx;
    logic [7:0] e_byte;
    bit         e_rdok;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int         p;
    logic [7:0] b;
    bit         s;
    logic [9:0] w;
    int         n;
    int         lat;
    int         hold;
    logic [7:0] tb;
    bit         full;
    bit         rdf;
    logic [7:0] eb;

    tbl[0]  = '{1'b0, 10'h0A5, 14, 0, 0, 8'h00, 1, 10'h0A5, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 10'h13C, 14, 1, 2, 8'h55, 1, 10'h13C, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 10'h2A5, 14, 0, 0, 8'h00, 1, 10'h2A5, 8'h00, 1'b1};
    tbl[3]  = '{1'b1, 10'h300, 24, 1, 1, 8'h3C, 1, 10'h300, 8'h3C, 1'b0};
    tbl[4]  = '{1'b0, 10'h1FF, 7,  0, 0, 8'h00, 0, 10'h300, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 10'h0FF, 12, 0, 0, 8'h00, 1, 10'h0FF, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 10'h155, 11, 0, 0, 8'h00, 0, 10'h0FF, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 10'h2C3, 12, 0, 0, 8'h00, 1, 10'h2C3, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 10'h301, 30, 4, 1, 8'h81, 1, 10'h301, 8'h81, 1'b0};
    tbl[9]  = '{1'b1, 10'h211, 13, 0, 0, 8'h00, 1, 10'h211, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 10'h3FF, 18, 1, 3, 8'hA5, 1, 10'h3FF, 8'hA0, 1'b1};
    tbl[11] = '{1'b1, 10'h0FE, 23, 1, 1, 8'h5A, 1, 10'h0FE, 8'h5A, 1'b0};

    total    = 0;
    bad      = 0;
    m_rd_ok  = 1'b0;
    m_rx     = '0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;

    #12;
    chk("rst_miso", 32'(miso), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rd_ok", 32'(dut.rd_addr_ok_q), 32'(0));

    for (int i = 0; i < 12; i++) begin
      run_frame(tbl[i].sel, tbl[i].word, tbl[i].n, tbl[i].lat,
                tbl[i].hold, tbl[i].txb, p, b);
      chk($sformatf("tbl%0d_pulses", i), 32'(p), 32'(tbl[i].e_pulses));
      chk($sformatf("tbl%0d_rx", i), 32'(rx_data), 32'(tbl[i].e_rx));
      chk($sformatf("tbl%0d_byte", i), 32'(b), 32'(tbl[i].e_byte));
      chk($sformatf("tbl%0d_rdok", i), 32'(dut.rd_addr_ok_q),
          32'(tbl[i].e_rdok));
    end

    // reset while MISO is shifting a read response
    run_frame(1'b1, 10'h0A0, 13, 0, 0, 8'h00, p, b);
    tx_data = 8'hC3;
    for (int e = 0; e <= 15; e++) begin
      @(negedge clk);
      ss_n     = 1'b0;
      mosi     = 1'b1;
      tx_valid = (e == 13);
      @(posedge clk);
      #1;
    end
    chk("rstrd_shifting", 32'(miso), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    m_rd_ok = 1'b0;
    m_rx    = '0;
    chk("rstrd_miso", 32'(miso), 32'(0));
    chk("rstrd_rx_valid", 32'(rx_valid), 32'(0));
    chk("rstrd_rx_data", 32'(rx_data), 32'(0));
    chk("rstrd_rd_ok", 32'(dut.rd_addr_ok_q), 32'(0));
    @(negedge clk);
    ss_n     = 1'b1;
    tx_valid = 1'b0;
    mosi     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b1, 10'h1C7, 14, 1, 1, 8'hFF, p, b);
    chk("rstrd_next_pulses", 32'(p), 32'(1));
    chk("rstrd_next_byte", 32'(b), 32'(0));
    chk("rstrd_next_rdok", 32'(dut.rd_addr_ok_q), 32'(1));

    // random frames
    for (int k = 0; k < 40; k++) begin
      s    = ($urandom_range(0, 3) != 0);
      w    = 10'($urandom);
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 13))
                                         : int'($urandom_range(12, 32));
      lat  = int'($urandom_range(0, 5));
      hold = int'($urandom_range(1, 3));
      tb   = 8'($urandom);
      full = (n >= 12);
      rdf  = full && s && m_rd_ok && (lat > 0);
      eb   = '0;
      if (rdf) begin
        for (int j = 0; j < 8; j++)
          if (13 + lat + j < n) eb[7-j] = tb[7-j];
      end
      run_frame(s, w, n, lat, hold, tb, p, b);
      chk("rnd_pulses", 32'(p), 32'(full ? 1 : 0));
      chk("rnd_byte", 32'(b), 32'(eb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end for the SPI-attached RAM. Deserialises MOSI frames into 10-bit command/data words with a one-cycle `rx_valid` strobe for the RAM. On a read-data command, it captures the RAM's 8-bit `tx_data`/`tx_valid` response and shifts it out on MISO. All logic runs on the system clock, with SPI pins sampled synchronously.

## Interface
- `ADDR_SIZE`, default 8: RAM data/address width; `rx_data` is `ADDR_SIZE+2` bits wide.
- `clk`, input, 1 bit: system clock; all state changes on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `SS_n`, input, 1 bit: slave select, active-low; a frame lasts while it is low.
- `MOSI`, input, 1 bit: serial data in, MSB first.
- `MISO`, output, 1 bit: serial data out, registered.
- `rx_data`, output, 10 bits: assembled word to the RAM; `[9:8]` is the opcode.
- `rx_valid`, output, 1 bit: one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data`, input, 8 bits: read data from the RAM.
- `tx_valid`, input, 1 bit: qualifies `tx_data`.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. State register is reset to IDLE.
- Internal flag `rd_addr_ok` is reset to 0.
- IDLE: moves to CHK_CMD on the first edge where `SS_n`=0.
- CHK_CMD: samples MOSI as the select bit.
  - 0 → WRITE.
  - 1 with `rd_addr_ok`=0 → READ_ADD.
  - 1 with `rd_addr_ok`=1 → READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift MOSI into a 10-bit shift register, MSB first, one bit per clock.
  - A 4-bit counter runs from 0 to 9.
  - After the 10th bit, `rx_data` loads the full word and `rx_valid`=1 for exactly one cycle.
  - Further MOSI bits in the same frame are ignored.
- READ_ADD completion sets `rd_addr_ok`.
- READ_DATA after `rx_valid`: waits for `tx_valid`.
  - On the first edge with `tx_valid`=1, loads `tx_data` into the output shift register.
  - MISO then presents bits 7 down to 0 on 8 consecutive cycles.
  - After bit 0, MISO returns to 0, `rd_addr_ok` clears, and `tx_valid` is ignored for the rest of the frame.
- The opcode in `rx_data[9:8]` is passed through unchecked; the select bit only chooses the FSM path.
- `SS_n`=1 in any state: next state is IDLE.
  - The bit counter and the output shift are cleared.
  - MISO goes to 0 and `rx_valid` goes to 0.
  - `rx_data` holds its last value; `rd_addr_ok` is kept.
- Frame aborted before the 10th bit: no `rx_valid`, and `rd_addr_ok` is unchanged.
- Reset values: `MISO`=0, `rx_valid`=0, `rx_data`=0, state IDLE, counters 0.
- Async reset mid-frame: all of the above take effect immediately, and the frame is lost.

## Timing
- Cycle numbering: edge 0 is where `SS_n`=0 is first sampled. CHK_CMD samples the select bit at edge 1.
- Data bits 9..0 are sampled at edges 2..11.
- `rx_valid` is high during the cycle after edge 11.
- RAM response: with a RAM returning `tx_valid` one edge after seeing `rx_valid`, `tx_data` is captured at edge 13. MISO carries bit 7 after edge 14 and bit 0 after edge 21.
- If `tx_valid` is late, MISO stays 0 until the capture edge; there is no timeout.
- `SS_n` rising on an edge that would raise `rx_valid`: SS_n wins, and `rx_valid` stays 0.
- `SS_n` low again the cycle after going high: a new frame starts. There is no minimum deselect time.

## Configuration
- `SPI_SLAVE_SVA_EN` defined compiles in concurrent assertions:
  - `rx_valid` is never high for 2 consecutive cycles.
  - The state is always one of the 5 legal encodings.
  - MISO=0 whenever `SS_n`=1.
  - `rd_addr_ok` toggles only on a completed READ_ADD or READ_DATA.
- `SPI_SLAVE_SVA_EN` undefined: no assertions, and functional behaviour is identical.

## Test plan
- Write address: `SS_n` low, MOSI 0 then `00_1010_0101`, `SS_n` high → `rx_data`=10'h0A5 with `rx_valid` for 1 cycle after edge 11; `rd_addr_ok` stays 0.
- Write data: select 0, word 10'h13C → `rx_data`=10'h13C and one `rx_valid`; MISO stays 0 throughout.
- Read address then read data:
  - Select 1 with word 10'h2A5 → `rx_data`=10'h2A5 and `rd_addr_ok`=1.
  - Next frame, select 1 with word 10'h300 and `tx_valid` returning `tx_data`=8'h3C → MISO reads 0,0,1,1,1,1,0,0, then `rd_addr_ok`=0.
- Abort: `SS_n` high after 5 data bits → no `rx_valid`, state IDLE, and a following full write frame of 10'h0FF is received correctly.
- Reset mid-read: `rst_n` low while MISO is shifting → MISO=0 and state IDLE immediately, `rd_addr_ok`=0, and the next select-1 frame enters READ_ADD.
- Late `tx_valid`: RAM asserts `tx_valid` 4 cycles after `rx_valid` with 8'h81 → MISO is 0 while waiting, then reads 1,0,0,0,0,0,0,1.
